// File: rtl/mult_arbiter_pkg.sv
// ============================================================================
// Module      : mult_arbiter_pkg
// Description : Shared types for the multiplier arbiter. These are the arbiter
//               FSM states and the multiplier controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_arbiter_pkg;

    // Multiplier controller state encoding, as reported on mult_state_i.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_BIT0 = 3'd1,
        ST_BIT1 = 3'd2,
        ST_BIT2 = 3'd3,
        ST_BIT3 = 3'd4,
        ST_END  = 3'd5
    } estado_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_RUN   = 2'd1,
        ARB_RESP  = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_t;

    localparam int c_mult_state_w = 3;

    // Width of a requester index. The width is never below 1, so that the
    // index always exists as a signal.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational winner selection. The search starts after the
//               pointer and wraps, or it is a plain priority encoder when
//               MULT_ARB_FIXED_PRIO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
    import mult_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_winner,
    output logic [IDX_W-1:0] o_idx
);

    logic w_found;

`ifdef MULT_ARB_FIXED_PRIO_EN
    // The pointer has no meaning under fixed priority.
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    always_comb begin
        o_winner = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req[i]) begin
                w_found     = 1'b1;
                o_winner[i] = 1'b1;
                o_idx       = IDX_W'(i);
            end
        end
    end
`else
    int w_cand;

    // The last winner has the lowest priority on the next search.
    always_comb begin
        o_winner = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_cand   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = (int'(i_ptr) + i) % N_REQ;
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_winner[w_cand] = 1'b1;
                o_idx            = IDX_W'(w_cand);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mult_arbiter.sv
// ============================================================================
// Module      : mult_arbiter
// Description : This module arbitrates N_REQ requesters onto one shared
//               sequential multiplier and returns the product with a done
//               pulse. Build option MULT_ARB_FIXED_PRIO_EN selects fixed
//               priority in place of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DATA_W-1:0]   a_i,
    input  logic [N_REQ*DATA_W-1:0]   b_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          done_o,
    output logic [2*DATA_W-1:0]       prod_o,
    output logic                      busy_o,
    output logic                      mult_strt_o,
    output logic [DATA_W-1:0]         mult_a_o,
    output logic [DATA_W-1:0]         mult_b_o,
    input  logic [c_mult_state_w-1:0] mult_state_i,
    input  logic [2*DATA_W-1:0]       mult_prod_i
);

    localparam int c_idx_w = idx_w(N_REQ);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic [N_REQ-1:0]    r_gnt,  w_gnt_nxt;
    logic [N_REQ-1:0]    r_done, w_done_nxt;
    logic [2*DATA_W-1:0] r_prod, w_prod_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_strt, w_strt_nxt;
    logic [DATA_W-1:0]   r_a,    w_a_nxt;
    logic [DATA_W-1:0]   r_b,    w_b_nxt;
    logic                w_take;

    logic [N_REQ-1:0]    w_winner;
    logic [c_idx_w-1:0]  w_idx;
    logic [c_idx_w-1:0]  w_ptr;
    logic [DATA_W-1:0]   w_a_sel;
    logic [DATA_W-1:0]   w_b_sel;
    logic                w_mult_end;
    logic                w_mult_idle;

    // Undefined encodings fail both compares. So ARB_RUN and ARB_DRAIN hold.
    assign w_mult_end  = (mult_state_i == ST_END);
    assign w_mult_idle = (mult_state_i == ST_IDLE);

`ifdef MULT_ARB_FIXED_PRIO_EN
    logic w_unused_take;
    assign w_unused_take = w_take;
    assign w_ptr         = '0;
`else
    localparam logic [c_idx_w-1:0] c_ptr_rst = c_idx_w'(N_REQ - 1);

    logic [c_idx_w-1:0] r_ptr;

    // At reset the pointer sits on the last index, so requester 0 is first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= c_ptr_rst;
        end else if (w_take) begin
            r_ptr <= w_idx;
        end
    end

    assign w_ptr = r_ptr;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (c_idx_w)
    ) u_picker (
        .i_req    (req_i),
        .i_ptr    (w_ptr),
        .o_winner (w_winner),
        .o_idx    (w_idx)
    );

    assign w_a_sel = a_i[int'(w_idx)*DATA_W +: DATA_W];
    assign w_b_sel = b_i[int'(w_idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_prod  <= '0;
            r_busy  <= 1'b0;
            r_strt  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_prod  <= w_prod_nxt;
            r_busy  <= w_busy_nxt;
            r_strt  <= w_strt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
        end
    end

    // Next-state logic. Each output is computed one cycle ahead, so that
    // every output comes straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_prod_nxt  = r_prod;
        w_busy_nxt  = r_busy;
        w_strt_nxt  = r_strt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_take      = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (|req_i) begin
                    w_state_nxt = ARB_RUN;
                    w_gnt_nxt   = w_winner;
                    w_a_nxt     = w_a_sel;
                    w_b_nxt     = w_b_sel;
                    w_busy_nxt  = 1'b1;
                    w_strt_nxt  = 1'b1;
                    w_take      = 1'b1;
                end
            end
            ARB_RUN: begin
                if (w_mult_end) begin
                    w_state_nxt = ARB_RESP;
                    w_prod_nxt  = mult_prod_i;
                    w_done_nxt  = r_gnt;
                    w_strt_nxt  = 1'b0;
                end
            end
            ARB_RESP: begin
                w_state_nxt = ARB_DRAIN;
                w_gnt_nxt   = '0;
            end
            ARB_DRAIN: begin
                if (w_mult_idle) begin
                    w_state_nxt = ARB_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_strt_nxt  = 1'b0;
            end
        endcase
    end

    assign gnt_o       = r_gnt;
    assign done_o      = r_done;
    assign prod_o      = r_prod;
    assign busy_o      = r_busy;
    assign mult_strt_o = r_strt;
    assign mult_a_o    = r_a;
    assign mult_b_o    = r_b;

endmodule

`default_nettype wire

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sequential shift-add multiplier among N_REQ requesters.
- The multiplier core is the 4-state-per-bit FSM: ST_IDLE, ST_BIT0..ST_BIT3, ST_END.
- This block selects a requester, latches its operands onto the multiplier inputs, and drives the multiplier start line.
- It tracks the multiplier state and returns the product with a one-cycle done pulse. It sits between the requester ports and the multiplier datapath/controller pair.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 4, operand width; product is 2*DATA_W

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_i  in  N_REQ  level request per requester
a_i  in  N_REQ*DATA_W  packed operand A; slice n belongs to requester n
b_i  in  N_REQ*DATA_W  packed operand B; slice n belongs to requester n
gnt_o  out  N_REQ  one-hot grant, held for the whole operation
done_o  out  N_REQ  one-cycle completion pulse to the granted requester
prod_o  out  2*DATA_W  product; valid when any done_o bit is high, held afterwards
busy_o  out  1  high in every state except ARB_IDLE
mult_strt_o  out  1  start line to the multiplier controller
mult_a_o  out  DATA_W  latched operand A to the datapath
mult_b_o  out  DATA_W  latched operand B to the datapath
mult_state_i  in  3  multiplier state (estado_t encoding)
mult_prod_i  in  2*DATA_W  multiplier product

Behaviour:
- Reset (rst_i high at a clk_i edge) sets:
  - state ARB_IDLE
  - gnt_o = 0, done_o = 0, prod_o = 0, busy_o = 0, mult_strt_o = 0, mult_a_o = 0, mult_b_o = 0
  - rr pointer = N_REQ-1, so requester 0 has first priority
- Reset mid-operation aborts with no done pulse. mult_strt_o is low from the next cycle. The multiplier returns to ST_IDLE through its own controller.
- All outputs are registered.
- FSM states: ARB_IDLE, ARB_RUN, ARB_RESP, ARB_DRAIN.
- ARB_IDLE:
  - If req_i != 0, pick the winner: first set bit searching from pointer+1 upward, wrapping modulo N_REQ.
  - Register gnt_o, mult_a_o and mult_b_o from the winner's slices. Set the pointer to the winner. Go to ARB_RUN.
  - Otherwise stay in ARB_IDLE.
- ARB_RUN:
  - mult_strt_o = 1.
  - When mult_state_i == ST_END, capture mult_prod_i into prod_o and go to ARB_RESP.
- ARB_RESP (1 cycle):
  - done_o = gnt_o, mult_strt_o = 0. Go to ARB_DRAIN.
- ARB_DRAIN:
  - gnt_o is cleared on entry.
  - Wait for mult_state_i == ST_IDLE, then go to ARB_IDLE.
- Latency: requester winning at edge t sees done_o at cycle t+7. The earliest next grant is registered at t+9, so throughput is one product per 9 cycles.
- Operands are sampled only at grant. Later changes on a_i/b_i are ignored.
- Requester dropping req_i while granted: the operation completes and done_o still pulses.
- Requester holding req_i after done_o is re-arbitrated as a new request.
- Simultaneous requests: exactly one grant; the others wait with no starvation. Each waits at most N_REQ-1 operations.
- mult_state_i equal to ST_END while in ARB_IDLE or ARB_DRAIN is ignored.
- Undefined mult_state_i encodings: treat as not-END in ARB_RUN and not-IDLE in ARB_DRAIN.

Optional Feature:
MULT_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest-index asserted request always wins. The rr pointer is not implemented. Starvation of high indices is permitted.
- Undefined: round-robin as specified above.

Decomposition:
- Package (multiplicador_defines.sv): arb_state_t enum (ARB_IDLE, ARB_RUN, ARB_RESP, ARB_DRAIN). Reuse the existing estado_t for comparisons on mult_state_i.
- Sub-module rr_picker: combinational; inputs req and pointer; outputs one-hot winner and index. Under MULT_ARB_FIXED_PRIO_EN it reduces to a priority encoder.

Test Plan:
- Reset → all outputs 0, state ARB_IDLE. Then req_i=0001, a=3, b=5 → gnt_o=0001 at t+1; done_o=0001 and prod_o=15 at t+7; busy_o low at t+9.
- req_i=1111 held constantly → grants in order 0,1,2,3,0, each 9 cycles apart. Operands 15×15 on requester 2 → prod_o=225.
- req_i=0101 simultaneous, then requester 0 re-requests immediately → requester 2 is granted before 0 is served again (round-robin). With MULT_ARB_FIXED_PRIO_EN → requester 0 is served twice first.
- Change a_i/b_i of the granted requester during ARB_RUN (7×9 latched, then 1×1 applied) → prod_o=63.
- rst_i asserted at t+4 of an operation → no done_o pulse, mult_strt_o=0 at t+5. A new request after reset is granted to requester 0.
- Drop req_i at t+2 → done_o still pulses at t+7 and no further grant follows.
